// File: rtl/riscv_nn_ex_result_buffer.sv
// riscv_nn_ex_result_buffer: 2-entry skid FIFO between ALU and writeback with youngest-entry forwarding and saturating stall counter
module riscv_nn_ex_result_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  alu_valid_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_cmp_i,
  input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
  input  logic                  alu_we_i,
  output logic                  alu_ready_o,
  output logic                  wb_valid_o,
  output logic [DATA_WIDTH-1:0] wb_result_o,
  output logic                  wb_cmp_o,
  output logic [ADDR_WIDTH-1:0] wb_waddr_o,
  output logic                  wb_we_o,
  input  logic                  wb_ready_i,
  output logic                  fwd_valid_o,
  output logic [ADDR_WIDTH-1:0] fwd_waddr_o,
  output logic [DATA_WIDTH-1:0] fwd_result_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);
  logic [DATA_WIDTH-1:0] res_q [2];
  logic [ADDR_WIDTH-1:0] waddr_q [2];
  logic [1:0]            cmp_q, we_q;
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;
  logic                  push, pop, yng;
  assign alu_ready_o  = ~rst & (cnt_q != 2'd2);
  assign wb_valid_o   = cnt_q != 2'd0;
  assign wb_result_o  = res_q[rd_ptr_q];
  assign wb_cmp_o     = cmp_q[rd_ptr_q];
  assign wb_waddr_o   = waddr_q[rd_ptr_q];
  assign wb_we_o      = wb_valid_o & we_q[rd_ptr_q];
  assign yng          = ~wr_ptr_q;
  assign fwd_valid_o  = wb_valid_o & we_q[yng];
  assign fwd_waddr_o  = waddr_q[yng];
  assign fwd_result_o = res_q[yng];
  assign stall_cnt_o  = stall_q;
  always_comb begin
    push     = alu_valid_i & alu_ready_o;
    pop      = wb_valid_o & wb_ready_i;
    wr_ptr_d = flush_i ? 1'b0 : wr_ptr_q ^ push;
    rd_ptr_d = flush_i ? 1'b0 : rd_ptr_q ^ pop;
    cnt_d    = flush_i ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    stall_d  = (wb_valid_o & ~wb_ready_i & ~&stall_q) ? stall_q + 1'b1 : stall_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q    <= '{default: '0};
      waddr_q  <= '{default: '0};
      cmp_q    <= '0;
      we_q     <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      if (push & ~flush_i) begin
        res_q[wr_ptr_q]   <= alu_result_i;
        waddr_q[wr_ptr_q] <= alu_waddr_i;
        cmp_q[wr_ptr_q]   <= alu_cmp_i;
        we_q[wr_ptr_q]    <= alu_we_i;
      end
    end
  end
endmodule

// File: tb/tb_riscv_nn_ex_result_buffer.sv
// tb_riscv_nn_ex_result_buffer: vector table plus scoreboard model of the ALU result buffer
module tb_riscv_nn_ex_result_buffer;
  logic        clk = 1'b0, rst = 1'b1, flush_i = 1'b0;
  logic        alu_valid_i = 1'b0, alu_cmp_i = 1'b0, alu_we_i = 1'b0, wb_ready_i = 1'b0;
  logic [31:0] alu_result_i = '0;
  logic [5:0]  alu_waddr_i = '0;
  logic        alu_ready_o, wb_valid_o, wb_cmp_o, wb_we_o, fwd_valid_o;
  logic [31:0] wb_result_o, fwd_result_o;
  logic [5:0]  wb_waddr_o, fwd_waddr_o;
  logic [15:0] stall_cnt_o;
  int          n_cmp = 0, n_bad = 0;
  logic        chk_en = 1'b0;
  typedef struct packed { logic [31:0] res; logic cmp; logic [5:0] wa; logic we; } ent_t;
  ent_t        q[$];
  logic [15:0] m_stall = '0;
  typedef struct {
    logic v; logic [31:0] res; logic [5:0] wa; logic we; logic rdy; logic fl;
    logic e_v; logic [31:0] e_res; logic e_we; logic e_rdy; logic e_fv; logic [31:0] e_fres;
  } vec_t;
  vec_t tbl [11];
  riscv_nn_ex_result_buffer dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .alu_valid_i(alu_valid_i),
    .alu_result_i(alu_result_i), .alu_cmp_i(alu_cmp_i), .alu_waddr_i(alu_waddr_i),
    .alu_we_i(alu_we_i), .alu_ready_o(alu_ready_o), .wb_valid_o(wb_valid_o),
    .wb_result_o(wb_result_o), .wb_cmp_o(wb_cmp_o), .wb_waddr_o(wb_waddr_o),
    .wb_we_o(wb_we_o), .wb_ready_i(wb_ready_i), .fwd_valid_o(fwd_valid_o),
    .fwd_waddr_o(fwd_waddr_o), .fwd_result_o(fwd_result_o), .stall_cnt_o(stall_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] res, input logic [5:0] wa, input logic we,
                       input logic rdy, input logic fl);
    alu_valid_i = v; alu_result_i = res; alu_waddr_i = wa; alu_we_i = we;
    alu_cmp_i = res[0]; wb_ready_i = rdy; flush_i = fl;
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sb_ready", alu_ready_o, ~rst & (q.size() != 2));
      chk("sb_valid", wb_valid_o, q.size() != 0);
      chk("sb_stall", stall_cnt_o, m_stall);
      if (q.size() != 0) begin
        chk("sb_result", wb_result_o, q[0].res);
        chk("sb_cmp", wb_cmp_o, q[0].cmp);
        chk("sb_waddr", wb_waddr_o, q[0].wa);
        chk("sb_we", wb_we_o, q[0].we);
        chk("sb_fwd_valid", fwd_valid_o, q[$].we);
        chk("sb_fwd_waddr", fwd_waddr_o, q[$].wa);
        chk("sb_fwd_result", fwd_result_o, q[$].res);
      end else begin
        chk("sb_we_empty", wb_we_o, 1'b0);
        chk("sb_fwd_empty", fwd_valid_o, 1'b0);
      end
      if (rst) begin
        q.delete();
        m_stall = '0;
      end else begin
        if (q.size() != 0 && !wb_ready_i && m_stall != 16'hFFFF) m_stall++;
        if (flush_i) q.delete();
        else begin
          logic pu;
          pu = alu_valid_i && q.size() != 2;
          if (q.size() != 0 && wb_ready_i) void'(q.pop_front());
          if (pu) q.push_back('{alu_result_i, alu_cmp_i, alu_waddr_i, alu_we_i});
        end
      end
    end
  end
  initial begin
    tbl[0]  = '{1, 32'hA5, 5, 1, 1, 0,  1, 32'hA5, 1, 1, 1, 32'hA5};
    tbl[1]  = '{0, 32'h0,  0, 0, 1, 0,  0, 32'h0,  0, 1, 0, 32'h0};
    tbl[2]  = '{1, 32'h11, 1, 1, 0, 0,  1, 32'h11, 1, 1, 1, 32'h11};
    tbl[3]  = '{1, 32'h22, 2, 1, 0, 0,  1, 32'h11, 1, 0, 1, 32'h22};
    tbl[4]  = '{1, 32'h99, 4, 1, 0, 0,  1, 32'h11, 1, 0, 1, 32'h22};
    tbl[5]  = '{0, 32'h0,  0, 0, 1, 0,  1, 32'h22, 1, 1, 1, 32'h22};
    tbl[6]  = '{0, 32'h0,  0, 0, 1, 0,  0, 32'h0,  0, 1, 0, 32'h0};
    tbl[7]  = '{1, 32'h5A, 7, 0, 0, 0,  1, 32'h5A, 0, 1, 0, 32'h0};
    tbl[8]  = '{1, 32'h66, 3, 1, 0, 0,  1, 32'h5A, 0, 0, 1, 32'h66};
    tbl[9]  = '{1, 32'h77, 1, 1, 1, 1,  0, 32'h0,  0, 1, 0, 32'h0};
    tbl[10] = '{0, 32'h0,  0, 0, 1, 0,  0, 32'h0,  0, 1, 0, 32'h0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", alu_ready_o, 1'b0);
    chk("rst_valid", wb_valid_o, 1'b0);
    chk("rst_result", wb_result_o, 32'h0);
    chk("rst_fwd_result", fwd_result_o, 32'h0);
    chk("rst_stall", stall_cnt_o, 16'h0);
    chk_en = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].res, tbl[i].wa, tbl[i].we, tbl[i].rdy, tbl[i].fl);
      step();
      chk($sformatf("vec%0d_valid", i), wb_valid_o, tbl[i].e_v);
      chk($sformatf("vec%0d_we", i), wb_we_o, tbl[i].e_we);
      chk($sformatf("vec%0d_ready", i), alu_ready_o, tbl[i].e_rdy);
      chk($sformatf("vec%0d_fwd_valid", i), fwd_valid_o, tbl[i].e_fv);
      if (tbl[i].e_v) chk($sformatf("vec%0d_result", i), wb_result_o, tbl[i].e_res);
      if (tbl[i].e_fv) chk($sformatf("vec%0d_fwd_result", i), fwd_result_o, tbl[i].e_fres);
    end
    drive(1, 32'h30, 8, 1, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h33 + i, 6'(10 + i), 1, 1, 0);
      step();
      chk("pp_valid", wb_valid_o, 1'b1);
      chk("pp_ready", alu_ready_o, 1'b1);
      chk("pp_result", wb_result_o, 32'h33 + i);
    end
    drive(0, 0, 0, 0, 1, 0);
    step();
    chk("pp_drained", wb_valid_o, 1'b0);
    drive(1, 32'hC0, 12, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (70000) step();
    chk("stall_sat", stall_cnt_o, 16'hFFFF);
    drive(0, 0, 0, 0, 0, 1);
    step();
    chk("stall_after_flush", stall_cnt_o, 16'hFFFF);
    chk("flush_valid", wb_valid_o, 1'b0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    chk("stall_rst", stall_cnt_o, 16'h0);
    chk("ready_in_rst", alu_ready_o, 1'b0);
    rst = 1'b0;
    step();
    drive(1, 32'h1, 9, 0, 0, 0);
    step();
    chk("we0_fwd_valid", fwd_valid_o, 1'b0);
    chk("we0_wb_we", wb_we_o, 1'b0);
    drive(1, 32'h2, 13, 1, 0, 0);
    step();
    chk("we1_fwd_valid", fwd_valid_o, 1'b1);
    drive(1, 32'h3, 14, 1, 1, 0);
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_valid", wb_valid_o, 1'b0);
    chk("mid_rst_result", wb_result_o, 32'h0);
    chk("mid_rst_waddr", wb_waddr_o, 32'h0);
    chk("mid_rst_we", wb_we_o, 1'b0);
    chk("mid_rst_fwd_valid", fwd_valid_o, 1'b0);
    chk("mid_rst_fwd_waddr", fwd_waddr_o, 32'h0);
    chk("mid_rst_fwd_result", fwd_result_o, 32'h0);
    chk("mid_rst_stall", stall_cnt_o, 16'h0);
    chk("mid_rst_ready", alu_ready_o, 1'b0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    step();
    chk("post_rst_ready", alu_ready_o, 1'b1);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
